rmii_receiver: RTL and testbench

//  RMII receive path, the counterpart of the team's RMII transmitter.
//  - Samples rx_d/crs_dv once per ref_clk (100 Mb/s, one dibit per cycle).
//  - Strips preamble/SFD and assembles LSB-first dibits into bytes.
//  - Presents each byte with valid/first/last flags; pulses done_o with length and status when the frame ends.
//  - Sits between the PHY RMII pins and the MAC frame checker / rx FIFO.

---
 rtl/rmii_receiver.sv | 199 +++++++++++++++++++
 tb/tb_rmii_receiver.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_receiver.sv
// RMII receive path: strips preamble/SFD, assembles LSB-first dibits into bytes,
// presents them one byte late with first/last flags and reports length/status per frame.
module rmii_receiver #(
    parameter int MIN_PRE_DIBITS  = 8,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int LEN_W           = 11
) (
    input  logic             ref_clk,
    input  logic             rst_n,
    input  logic [1:0]       rx_d,
    input  logic             crs_dv,
    input  logic             rx_er,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] len_o
);

    localparam int                 PRE_W     = $clog2(MIN_PRE_DIBITS + 1);
    localparam logic [PRE_W-1:0]   PRE_SAT   = PRE_W'(MIN_PRE_DIBITS);
    localparam logic [LEN_W:0]     MAX_BYTES = (LEN_W + 1)'(MAX_FRAME_BYTES);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] preCnt_q, preCnt_d;
    logic [1:0]       dibitCnt_q, dibitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             held_q, held_d;
    logic [LEN_W-1:0] byteCnt_q, byteCnt_d;
    logic [LEN_W-1:0] emitCnt_q, emitCnt_d;
    logic             pend_q, pend_d;
    logic             pendErr_q, pendErr_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [7:0]       newByte;
    logic [LEN_W:0]   byteCntInc;

    assign newByte    = {rx_d, shift_q[7:2]};
    assign byteCntInc = {1'b0, byteCnt_q} + 1'b1;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            preCnt_q   <= '0;
            dibitCnt_q <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            held_q     <= 1'b0;
            byteCnt_q  <= '0;
            emitCnt_q  <= '0;
            pend_q     <= 1'b0;
            pendErr_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            preCnt_q   <= preCnt_d;
            dibitCnt_q <= dibitCnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            byteCnt_q  <= byteCnt_d;
            emitCnt_q  <= emitCnt_d;
            pend_q     <= pend_d;
            pendErr_q  <= pendErr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_q      <= err_d;
            len_q      <= len_d;
        end
    end

    // Status goes out one edge after the frame-ending event, so done never coincides with valid.
    always_comb begin
        state_d    = state_q;
        preCnt_d   = preCnt_q;
        dibitCnt_d = dibitCnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        held_d     = held_q;
        byteCnt_d  = byteCnt_q;
        emitCnt_d  = emitCnt_q;
        pend_d     = 1'b0;
        pendErr_d  = pendErr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        done_d     = pend_q;
        err_d      = pend_q & pendErr_q;
        len_d      = pend_q ? emitCnt_q : '0;

        case (state_q)
            IDLE: begin
                if (crs_dv && !rx_er && rx_d == 2'b01) begin
                    state_d  = PRE;
                    preCnt_d = PRE_W'(1);
                end
            end
            PRE: begin
                state_d = IDLE;
                if (crs_dv && !rx_er) begin
                    if (rx_d == 2'b01) begin
                        state_d = PRE;
                        if (preCnt_q != PRE_SAT) preCnt_d = preCnt_q + 1'b1;
                    end else if (rx_d == 2'b11 && preCnt_q >= PRE_SAT) begin
                        state_d    = DATA;
                        dibitCnt_d = '0;
                        byteCnt_d  = '0;
                        emitCnt_d  = '0;
                        held_d     = 1'b0;
                        shift_d    = '0;
                    end
                end
            end
            DATA: begin
                if (!crs_dv) begin
                    state_d   = IDLE;
                    pend_d    = 1'b1;
                    pendErr_d = 1'b1;
                    held_d    = 1'b0;
                    if (dibitCnt_q == 2'd0 && held_q) begin
                        data_d    = hold_q;
                        valid_d   = 1'b1;
                        first_d   = (emitCnt_q == '0);
                        last_d    = 1'b1;
                        emitCnt_d = emitCnt_q + 1'b1;
                        pendErr_d = 1'b0;
                    end
                end else begin
                    shift_d    = newByte;
                    dibitCnt_d = dibitCnt_q + 1'b1;
                    if (dibitCnt_q == 2'd3) begin
                        if (byteCntInc > MAX_BYTES) begin
                            state_d   = DROP;
                            pend_d    = 1'b1;
                            pendErr_d = 1'b1;
                            held_d    = 1'b0;
                        end else begin
                            // The previously held byte is clean even if rx_er taints the one completing now.
                            if (held_q) begin
                                data_d    = hold_q;
                                valid_d   = 1'b1;
                                first_d   = (emitCnt_q == '0);
                                emitCnt_d = emitCnt_q + 1'b1;
                            end
                            hold_d    = newByte;
                            held_d    = 1'b1;
                            byteCnt_d = byteCntInc[LEN_W-1:0];
                            if (rx_er) begin
                                state_d   = DROP;
                                pend_d    = 1'b1;
                                pendErr_d = 1'b1;
                                held_d    = 1'b0;
                            end
                        end
                    end else if (rx_er) begin
                        state_d   = DROP;
                        pend_d    = 1'b1;
                        pendErr_d = 1'b1;
                        held_d    = 1'b0;
                    end
                end
            end
            DROP: begin
                if (!crs_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign first_o = first_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign len_o   = len_q;

endmodule

// File: tb/tb_rmii_receiver.sv
// Scoreboard bench for rmii_receiver: expected bytes and frame status are queued as
// frames are driven, DUT events are captured on the falling edge and compared per scenario.
`timescale 1ns/1ps
module tb_rmii_receiver;

    localparam int LEN_W     = 11;
    localparam int MAX_BYTES = 4;

    logic             ref_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic [1:0]       rx_d    = 2'b00;
    logic             crs_dv  = 1'b0;
    logic             rx_er   = 1'b0;
    logic [7:0]       data_o;
    logic             valid_o, first_o, last_o, done_o, err_o;
    logic [LEN_W-1:0] len_o;

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
        int         cyc;
    } byteEv_t;

    typedef struct {
        logic             err;
        logic [LEN_W-1:0] len;
        int               cyc;
    } doneEv_t;

    byteEv_t expBytes[$], obsBytes[$];
    doneEv_t expDone[$], obsDone[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      cycle      = 0;
    bit      collide    = 1'b0;

    rmii_receiver #(
        .MIN_PRE_DIBITS (8),
        .MAX_FRAME_BYTES(MAX_BYTES),
        .LEN_W          (LEN_W)
    ) dut (
        .ref_clk(ref_clk),
        .rst_n  (rst_n),
        .rx_d   (rx_d),
        .crs_dv (crs_dv),
        .rx_er  (rx_er),
        .data_o (data_o),
        .valid_o(valid_o),
        .first_o(first_o),
        .last_o (last_o),
        .done_o (done_o),
        .err_o  (err_o),
        .len_o  (len_o)
    );

    always #10 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cycle++;

    // Capture every DUT strobe half a cycle after the edge that produced it.
    always @(negedge ref_clk) begin
        byteEv_t b;
        doneEv_t d;
        if (valid_o) begin
            b.data = data_o; b.first = first_o; b.last = last_o; b.cyc = cycle;
            obsBytes.push_back(b);
        end
        if (done_o) begin
            d.err = err_o; d.len = len_o; d.cyc = cycle;
            obsDone.push_back(d);
        end
        if (valid_o && done_o) collide = 1'b1;
    end

    task automatic drive(input logic dv, input logic [1:0] d, input logic er);
        @(posedge ref_clk);
        #2;
        crs_dv = dv;
        rx_d   = d;
        rx_er  = er;
    endtask

    task automatic sendPreamble(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b, input int erDibit);
        for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2], 1'(i == erDibit));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0);
    endtask

    task automatic expectByte(input logic [7:0] d, input logic f, input logic l);
        byteEv_t e;
        e.data = d; e.first = f; e.last = l; e.cyc = 0;
        expBytes.push_back(e);
    endtask

    task automatic expectDone(input logic er, input int len);
        doneEv_t e;
        e.err = er; e.len = LEN_W'(len); e.cyc = 0;
        expDone.push_back(e);
    endtask

    task automatic flush();
        expBytes.delete(); obsBytes.delete(); expDone.delete(); obsDone.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        @(negedge ref_clk);
        compared++;
        if ({data_o, valid_o, first_o, last_o, done_o, err_o, len_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got data=%h v=%b f=%b l=%b d=%b e=%b len=%0d, want all 0",
                     data_o, valid_o, first_o, last_o, done_o, err_o, len_o);
        end
        @(posedge ref_clk);
        #2 rst_n = 1'b1;
        idle(2);
        flush();
    endtask

    task automatic test_good_frame();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        int      lastCyc = 0;
        expectByte(8'hC3, 1'b1, 1'b0);
        expectByte(8'h91, 1'b0, 1'b1);
        expectDone(1'b0, 2);
        sendPreamble(28);
        sendByte(8'hC3, -1);
        sendByte(8'h91, -1);
        idle(6);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL good_frame counts: got %0d bytes/%0d done, want %0d/%0d",
                     obsBytes.size(), obsDone.size(), expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            lastCyc = ob.cyc;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last) begin
                mismatched++;
                $display("[TB] FAIL good_frame byte: got %h f%b l%b, want %h f%b l%b",
                         ob.data, ob.first, ob.last, eb.data, eb.first, eb.last);
            end
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len || od.cyc != lastCyc + 1) begin
                mismatched++;
                $display("[TB] FAIL good_frame done: got err=%b len=%0d at +%0d, want err=%b len=%0d at +1",
                         od.err, od.len, od.cyc - lastCyc, ed.err, ed.len);
            end
        end
        flush();
    endtask

    task automatic test_short_preamble();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        sendPreamble(4);
        sendByte(8'hC3, -1);
        idle(3);
        sendPreamble(7);
        sendByte(8'hC3, -1);
        idle(3);
        compared++;
        if (obsBytes.size() != 0 || obsDone.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL short_preamble: got %0d bytes/%0d done, want 0/0",
                     obsBytes.size(), obsDone.size());
        end
        flush();
        expectByte(8'h5A, 1'b1, 1'b1);
        expectDone(1'b0, 1);
        sendPreamble(8);
        sendByte(8'h5A, -1);
        idle(4);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL min_preamble counts: got %0d bytes/%0d done, want %0d/%0d",
                     obsBytes.size(), obsDone.size(), expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last) begin
                mismatched++;
                $display("[TB] FAIL min_preamble byte: got %h f%b l%b, want %h f%b l%b",
                         ob.data, ob.first, ob.last, eb.data, eb.first, eb.last);
            end
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len) begin
                mismatched++;
                $display("[TB] FAIL min_preamble done: got err=%b len=%0d, want err=%b len=%0d",
                         od.err, od.len, ed.err, ed.len);
            end
        end
        flush();
    endtask

    task automatic test_misaligned();
        doneEv_t ed, od;
        expectDone(1'b1, 0);
        expectDone(1'b1, 0);
        sendPreamble(10);
        sendByte(8'hC3, -1);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        idle(4);
        sendPreamble(10);
        idle(4);
        compared++;
        if (obsBytes.size() != 0 || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL misaligned counts: got %0d bytes/%0d done, want 0/%0d",
                     obsBytes.size(), obsDone.size(), expDone.size());
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len) begin
                mismatched++;
                $display("[TB] FAIL misaligned done: got err=%b len=%0d, want err=%b len=%0d",
                         od.err, od.len, ed.err, ed.len);
            end
        end
        flush();
    endtask

    task automatic test_max_length();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        int      prevCyc = -1;
        for (int i = 1; i <= MAX_BYTES; i++) expectByte(8'(i * 16), 1'(i == 1), 1'(i == MAX_BYTES));
        expectDone(1'b0, MAX_BYTES);
        sendPreamble(9);
        for (int i = 1; i <= MAX_BYTES; i++) sendByte(8'(i * 16), -1);
        idle(4);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL max_length counts: got %0d bytes/%0d done, want %0d/%0d",
                     obsBytes.size(), obsDone.size(), expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last ||
                (prevCyc >= 0 && !eb.last && ob.cyc - prevCyc != 4)) begin
                mismatched++;
                $display("[TB] FAIL max_length byte: got %h f%b l%b gap %0d, want %h f%b l%b gap 4",
                         ob.data, ob.first, ob.last, ob.cyc - prevCyc, eb.data, eb.first, eb.last);
            end
            prevCyc = ob.cyc;
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len) begin
                mismatched++;
                $display("[TB] FAIL max_length done: got err=%b len=%0d, want err=%b len=%0d",
                         od.err, od.len, ed.err, ed.len);
            end
        end
        flush();
    endtask

    task automatic test_overflow();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        int      dropCyc;
        for (int i = 1; i <= 3; i++) expectByte(8'(i), 1'(i == 1), 1'b0);
        expectDone(1'b1, 3);
        sendPreamble(8);
        for (int i = 1; i <= 6; i++) sendByte(8'(i), -1);
        dropCyc = cycle;
        idle(5);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL overflow counts: got %0d bytes/%0d done, want %0d/%0d",
                     obsBytes.size(), obsDone.size(), expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last) begin
                mismatched++;
                $display("[TB] FAIL overflow byte: got %h f%b l%b, want %h f%b l%b",
                         ob.data, ob.first, ob.last, eb.data, eb.first, eb.last);
            end
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len || od.cyc > dropCyc) begin
                mismatched++;
                $display("[TB] FAIL overflow done: got err=%b len=%0d cyc=%0d, want err=%b len=%0d cyc<=%0d",
                         od.err, od.len, od.cyc, ed.err, ed.len, dropCyc);
            end
        end
        flush();
    endtask

    task automatic test_rx_error();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        logic [7:0] frame [5];
        frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44; frame[4] = 8'h55;
        expectByte(frame[0], 1'b1, 1'b0);
        expectByte(frame[1], 1'b0, 1'b0);
        expectDone(1'b1, 2);
        sendPreamble(12);
        for (int i = 0; i < 5; i++) sendByte(frame[i], (i == 2) ? 3 : -1);
        idle(4);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL rx_error counts: got %0d bytes/%0d done, want %0d/%0d",
                     obsBytes.size(), obsDone.size(), expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last) begin
                mismatched++;
                $display("[TB] FAIL rx_error byte: got %h f%b l%b, want %h f%b l%b",
                         ob.data, ob.first, ob.last, eb.data, eb.first, eb.last);
            end
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len) begin
                mismatched++;
                $display("[TB] FAIL rx_error done: got err=%b len=%0d, want err=%b len=%0d",
                         od.err, od.len, ed.err, ed.len);
            end
        end
        flush();
    endtask

    task automatic test_reset_mid_frame();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        expectByte(8'h5A, 1'b1, 1'b0);
        sendPreamble(10);
        sendByte(8'h5A, -1);
        sendByte(8'hA5, -1);
        drive(1'b1, 2'b00, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        rst_n  = 1'b0;
        crs_dv = 1'b0;
        @(negedge ref_clk);
        compared++;
        if ({data_o, valid_o, first_o, last_o, done_o, err_o, len_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_frame outputs: got data=%h v=%b d=%b len=%0d, want all 0",
                     data_o, valid_o, done_o, len_o);
        end
        idle(2);
        @(posedge ref_clk);
        #2 rst_n = 1'b1;
        idle(2);
        expectByte(8'hAA, 1'b1, 1'b1);
        expectDone(1'b0, 1);
        sendPreamble(8);
        sendByte(8'hAA, -1);
        idle(4);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size()) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_frame counts: got %0d bytes/%0d done, want %0d/%0d",
                     obsBytes.size(), obsDone.size(), expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_frame byte: got %h f%b l%b, want %h f%b l%b",
                         ob.data, ob.first, ob.last, eb.data, eb.first, eb.last);
            end
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len) begin
                mismatched++;
                $display("[TB] FAIL reset_mid_frame done: got err=%b len=%0d, want err=%b len=%0d",
                         od.err, od.len, ed.err, ed.len);
            end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        byteEv_t eb, ob;
        doneEv_t ed, od;
        expectByte(8'h55, 1'b1, 1'b1);
        expectDone(1'b0, 1);
        expectByte(8'h12, 1'b1, 1'b0);
        expectByte(8'h34, 1'b0, 1'b1);
        expectDone(1'b0, 2);
        sendPreamble(8);
        sendByte(8'h55, -1);
        idle(1);
        sendPreamble(8);
        sendByte(8'h12, -1);
        sendByte(8'h34, -1);
        idle(4);
        compared++;
        if (obsBytes.size() != expBytes.size() || obsDone.size() != expDone.size() || collide) begin
            mismatched++;
            $display("[TB] FAIL back_to_back counts: got %0d bytes/%0d done collide=%b, want %0d/%0d collide=0",
                     obsBytes.size(), obsDone.size(), collide, expBytes.size(), expDone.size());
        end
        while (expBytes.size() != 0 && obsBytes.size() != 0) begin
            eb = expBytes.pop_front(); ob = obsBytes.pop_front(); compared++;
            if (ob.data !== eb.data || ob.first !== eb.first || ob.last !== eb.last) begin
                mismatched++;
                $display("[TB] FAIL back_to_back byte: got %h f%b l%b, want %h f%b l%b",
                         ob.data, ob.first, ob.last, eb.data, eb.first, eb.last);
            end
        end
        while (expDone.size() != 0 && obsDone.size() != 0) begin
            ed = expDone.pop_front(); od = obsDone.pop_front(); compared++;
            if (od.err !== ed.err || od.len !== ed.len) begin
                mismatched++;
                $display("[TB] FAIL back_to_back done: got err=%b len=%0d, want err=%b len=%0d",
                         od.err, od.len, ed.err, ed.len);
            end
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_preamble();
        test_misaligned();
        test_max_length();
        test_overflow();
        test_rx_error();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
